serv_bufreg_seq: RTL and testbench

- Self-sequencing, parametrised buffer register for the bit-serial core. Generalised to XLEN 32/64.
- Owns its beat counter and a start/done handshake; the decoder no longer supplies per-cycle count strobes.
- Accumulate mode builds rs1+imm serially, giving the data-bus address and the low address bits.
- Drain mode streams the stored word out with a sub-beat left/right shift and sign/zero fill.

---
 rtl/serv_bufreg_seq.sv | 152 +++++++++++++++
 tb/tb_serv_bufreg_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serv_bufreg_seq.sv
// Self-sequencing bit-serial buffer register: serial rs1+imm accumulate
// and shifted, sign/zero-filled drain of the stored word.
module serv_bufreg_seq #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int MDU            = 0
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_start,
   input  logic                                i_init,
   input  logic                                i_rs1_en,
   input  logic                                i_imm_en,
   input  logic                                i_clr_lsb,
   input  logic                                i_sh_signed,
   input  logic                                i_right_shift,
   input  logic [$clog2(BITS_PER_CYCLE):0]     i_shift_amt,
   input  logic                                i_stall,
   input  logic                                i_mdu_op,
   input  logic [BITS_PER_CYCLE-1:0]           i_rs1,
   input  logic [BITS_PER_CYCLE-1:0]           i_imm,
   output logic                                o_busy,
   output logic                                o_valid,
   output logic                                o_done,
   output logic [BITS_PER_CYCLE-1:0]           o_q,
   output logic [((XLEN == 32) ? 2 : 3)-1:0]   o_lsb,
   output logic [XLEN-1:0]                     o_dbus_adr,
   output logic [XLEN-1:0]                     o_ext_rs1
);

   localparam int B  = BITS_PER_CYCLE;
   localparam int N  = XLEN / B;
   localparam int LB = $clog2(B);
   localparam int AW = (XLEN == 32) ? 2 : 3;
   localparam int CW = $clog2(N);

   if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("serv_bufreg_seq: XLEN must be 32 or 64");
   end
   if (!(B == 1 || B == 2 || B == 4 || B == 8)) begin : g_bad_b
      $error("serv_bufreg_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            carry;
   logic [XLEN-1:0] data;
   logic [B-1:0]    prev;
   logic [AW-1:0]   lsb;
   logic            init, rs1_en, imm_en, clr_lsb, sh_signed, right_shift;
   logic [LB:0]     shamt;

   logic            accept, beat, last, fill;
   logic [B:0]      sum;
   logic [B-1:0]    q_acc, q_drn;
   logic [2*B-1:0]  win_l, win_r;
   logic [LB+1:0]   amt_l;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = RUN;
               accept    = 1'b1;
            end
         end
         RUN: begin
            if (beat && last) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = i_start ? RUN : IDLE;
            accept    = i_start;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign beat = (state == RUN) && !i_stall;
   assign last = (cnt == CW'(N - 1));
   assign fill = sh_signed & data[XLEN-1];

   always_comb begin
      sum = (B+1)'(rs1_en ? i_rs1 : '0)
          + (B+1)'(imm_en ? i_imm : '0)
          + (B+1)'(carry);
      q_acc = sum[B-1:0];
      if (clr_lsb && cnt == '0) q_acc[0] = 1'b0;
   end

   // Left shift pulls the top s bits of the previous beat in below the current one.
   assign win_l = {data[B-1:0], prev};
   assign win_r = data[2*B-1:0];
   assign amt_l = (LB+2)'(B) - (LB+2)'(shamt);
   assign q_drn = right_shift ? B'(win_r >> shamt) : B'(win_l >> amt_l);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         carry       <= 1'b0;
         data        <= '0;
         prev        <= '0;
         lsb         <= '0;
         init        <= 1'b0;
         rs1_en      <= 1'b0;
         imm_en      <= 1'b0;
         clr_lsb     <= 1'b0;
         sh_signed   <= 1'b0;
         right_shift <= 1'b0;
         shamt       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt         <= '0;
            carry       <= 1'b0;
            prev        <= '0;
            init        <= i_init;
            rs1_en      <= i_rs1_en;
            imm_en      <= i_imm_en;
            clr_lsb     <= i_clr_lsb;
            sh_signed   <= i_sh_signed;
            right_shift <= i_right_shift;
            shamt       <= i_shift_amt;
         end else if (beat) begin
            cnt <= cnt + CW'(1);
            if (init) begin
               carry <= sum[B];
               data  <= {q_acc, data[XLEN-1:B]};
               for (int i = 0; i < AW; i++) begin
                  if (cnt == CW'(i / B)) lsb[i] <= q_acc[i % B];
               end
            end else begin
               data <= {{B{fill}}, data[XLEN-1:B]};
               prev <= data[B-1:0];
            end
         end
      end
   end

   assign o_busy     = (state == RUN);
   assign o_valid    = beat;
   assign o_done     = (state == DONE);
   assign o_q        = (beat && !init) ? q_drn : '0;
   assign o_lsb      = ((MDU != 0) && i_mdu_op) ? '0 : lsb;
   assign o_dbus_adr = {data[XLEN-1:AW], AW'(0)};
   assign o_ext_rs1  = data;

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Directed bench for serv_bufreg_seq: accumulate, drain, stall, reset,
// back-to-back start, B=1 variant and MDU lsb masking.
module tb_serv_bufreg_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, init, rs1_en, imm_en, clr_lsb;
   logic        sh_signed, right_shift, stall, mdu_op;
   logic [2:0]  shift_amt;
   logic [3:0]  rs1, imm;
   logic        busy, valid, done;
   logic [3:0]  q;
   logic [1:0]  lsb;
   logic [31:0] adr, ext;

   logic        b_start, b_rs1, b_imm;
   logic [0:0]  b_shamt;
   logic        b_busy, b_valid, b_done;
   logic [0:0]  b_q;
   logic [1:0]  b_lsb;
   logic [31:0] b_adr, b_ext;

   int errors = 0;
   int checks = 0;
   int d;

   always #5 clk = ~clk;

   serv_bufreg_seq #(.XLEN(32), .BITS_PER_CYCLE(4), .MDU(1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_init(init),
      .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
      .i_sh_signed(sh_signed), .i_right_shift(right_shift),
      .i_shift_amt(shift_amt), .i_stall(stall), .i_mdu_op(mdu_op),
      .i_rs1(rs1), .i_imm(imm), .o_busy(busy), .o_valid(valid),
      .o_done(done), .o_q(q), .o_lsb(lsb), .o_dbus_adr(adr),
      .o_ext_rs1(ext)
   );

   serv_bufreg_seq #(.XLEN(32), .BITS_PER_CYCLE(1), .MDU(0)) u_b1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_init(init),
      .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
      .i_sh_signed(sh_signed), .i_right_shift(right_shift),
      .i_shift_amt(b_shamt), .i_stall(stall), .i_mdu_op(mdu_op),
      .i_rs1(b_rs1), .i_imm(b_imm), .o_busy(b_busy), .o_valid(b_valid),
      .o_done(b_done), .o_q(b_q), .o_lsb(b_lsb), .o_dbus_adr(b_adr),
      .o_ext_rs1(b_ext)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // st_at/st_len: stall window; pl: beat to pulse start on;
   // ab: beat to assert reset on; chain: restart in the DONE cycle.
   task automatic acc(input logic [31:0] a, input logic [31:0] b,
                      input logic clr, input int st_at, input int st_len,
                      input int pl, input int ab, input logic chain,
                      output int dcyc);
      int k, ns, cyc;
      logic hit;
      init = 1'b1; rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = clr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; clr_lsb = 1'b0;
      k = 0; ns = 0; cyc = 1; dcyc = -1; hit = 1'b0;
      while (cyc < 60 && dcyc < 0 && !hit) begin
         stall = (k == st_at) && (ns < st_len);
         start = (k == pl);
         if (k < 8 && !stall) begin
            rs1 = a[4*k +: 4];
            imm = b[4*k +: 4];
         end else begin
            rs1 = 4'hF;
            imm = 4'hF;
         end
         if (k >= 8) begin
            rs1 = 4'h0;
            imm = 4'h0;
         end
         rst_n = !(k == ab);
         #1;
         if (!rst_n) begin
            hit = 1'b1;
         end else if (done) begin
            dcyc  = cyc;
            start = chain;
         end else begin
            chk("acc_busy", 64'(busy), 64'(1));
            chk("acc_valid", 64'(valid), 64'(!stall));
            chk("acc_q", 64'(q), 64'(0));
         end
         if (stall) ns++;
         else k++;
         @(negedge clk);
         cyc++;
      end
      stall = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic acc1(input logic [31:0] a, input logic [31:0] b,
                       input logic clr, output int dcyc);
      int k, cyc;
      init = 1'b1; rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = clr;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0; clr_lsb = 1'b0;
      k = 0; cyc = 1; dcyc = -1;
      while (cyc < 60 && dcyc < 0) begin
         b_rs1 = (k < 32) ? a[k] : 1'b0;
         b_imm = (k < 32) ? b[k] : 1'b0;
         #1;
         if (b_done) dcyc = cyc;
         else chk("b1_busy", 64'(b_busy), 64'(1));
         k++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic drain(input logic r, input logic sg, input logic [2:0] s,
                        input logic [31:0] expq, input logic [31:0] fin);
      init = 1'b0; right_shift = r; sh_signed = sg; shift_amt = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; init = 1'b1; sh_signed = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("drn_valid", 64'(valid), 64'(1));
         chk("drn_q", 64'(q), 64'(expq[4*k +: 4]));
         @(negedge clk);
      end
      #1;
      chk("drn_done", 64'(done), 64'(1));
      chk("drn_final", 64'(ext), 64'(fin));
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; init = 1'b0; rs1_en = 1'b0;
      imm_en = 1'b0; clr_lsb = 1'b0; sh_signed = 1'b0;
      right_shift = 1'b0; stall = 1'b0; mdu_op = 1'b0;
      shift_amt = 3'd0; rs1 = 4'h0; imm = 4'h0;
      b_start = 1'b0; b_rs1 = 1'b0; b_imm = 1'b0; b_shamt = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_valid", 64'(valid), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_q", 64'(q), 64'(0));
      chk("rst_lsb", 64'(lsb), 64'(0));
      chk("rst_ext", 64'(ext), 64'(0));
      rst_n = 1'b1;

      acc(32'h1000_0003, 32'h0000_0FFD, 1'b0, -1, 0, -1, -1, 1'b0, d);
      chk("t1_done_cyc", 64'(d), 64'(9));
      chk("t1_ext", 64'(ext), 64'h1000_1000);
      chk("t1_lsb", 64'(lsb), 64'(0));

      acc(32'h2000_0000, 32'h0000_0007, 1'b1, -1, 0, -1, -1, 1'b0, d);
      chk("t2_ext", 64'(ext), 64'h2000_0006);
      chk("t2_adr", 64'(adr), 64'h2000_0004);
      chk("t2_lsb", 64'(lsb), 64'(2));
      mdu_op = 1'b1;
      #1;
      chk("t6_mdu_lsb", 64'(lsb), 64'(0));
      mdu_op = 1'b0;
      #1;
      chk("t6_nomdu_lsb", 64'(lsb), 64'(2));

      acc1(32'h2000_0000, 32'h0000_0007, 1'b1, d);
      chk("t2b1_done_cyc", 64'(d), 64'(33));
      chk("t2b1_ext", 64'(b_ext), 64'h2000_0006);
      chk("t2b1_adr", 64'(b_adr), 64'h2000_0004);
      chk("t2b1_lsb", 64'(b_lsb), 64'(2));

      acc(32'h8000_0001, 32'h0, 1'b0, -1, 0, -1, -1, 1'b0, d);
      drain(1'b0, 1'b0, 3'd3, 32'h0000_0008, 32'h0000_0000);
      acc(32'h8000_0010, 32'h0, 1'b0, -1, 0, -1, -1, 1'b0, d);
      drain(1'b1, 1'b1, 3'd1, 32'hC000_0008, 32'hFFFF_FFFF);
      acc(32'h1234_5678, 32'h0, 1'b0, -1, 0, -1, -1, 1'b0, d);
      drain(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0000_0000);

      acc(32'h1000_0003, 32'h0000_0FFD, 1'b0, 4, 3, -1, -1, 1'b0, d);
      chk("t4_done_cyc", 64'(d), 64'(12));
      chk("t4_ext", 64'(ext), 64'h1000_1000);

      acc(32'h1000_0003, 32'h0000_0FFD, 1'b0, -1, 0, -1, 5, 1'b0, d);
      #1;
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_done", 64'(done), 64'(0));
      chk("t5_ext", 64'(ext), 64'(0));
      @(negedge clk);
      #1;
      chk("t5_nodone", 64'(done), 64'(0));
      acc(32'h1000_0003, 32'h0000_0FFD, 1'b0, -1, 0, 3, -1, 1'b0, d);
      chk("t5_pulse_cyc", 64'(d), 64'(9));
      chk("t5_pulse_ext", 64'(ext), 64'h1000_1000);

      acc(32'h1000_0003, 32'h0000_0FFD, 1'b0, -1, 0, -1, -1, 1'b1, d);
      start = 1'b0;
      #1;
      chk("t6_chain_busy", 64'(busy), 64'(1));
      d = 1;
      while (!done && d < 40) begin
         @(negedge clk);
         d++;
         #1;
      end
      chk("t6_chain_cyc", 64'(d), 64'(9));
      chk("t6_chain_ext", 64'(ext), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
